// File: rtl/window_stream_gen_if.sv
// rtl/window_stream_gen_if.sv - pixel-in / window-out stream bundle for window_stream_gen
//
// Purpose: groups the input pixel stream and the output window stream handshakes.
// Signals:
//   in_data   CHANNELS*PIX_W      one pixel per channel, channel n at [n*PIX_W +: PIX_W]
//   in_valid  1                   input beat valid
//   in_rdy    1                   input beat accepted when in_valid & in_rdy
//   out_data  CHANNELS*K*K*PIX_W  window per channel, channel n at base n*K*K*PIX_W
//   out_valid 1                   window valid
//   out_rdy   1                   window consumed when out_valid & out_rdy
//   out_last  1                   final window of the image
// Modports: slave = window generator side, master = pixel source / window sink side.
interface window_stream_gen_if #(
  parameter int PIX_W    = 8,
  parameter int CHANNELS = 1,
  parameter int K        = 3
);
  logic [CHANNELS*PIX_W-1:0]     in_data;
  logic                          in_valid;
  logic                          in_rdy;
  logic [CHANNELS*K*K*PIX_W-1:0] out_data;
  logic                          out_valid;
  logic                          out_rdy;
  logic                          out_last;

  modport master (
    output in_data, in_valid, out_rdy,
    input  in_rdy, out_data, out_valid, out_last
  );

  modport slave (
    input  in_data, in_valid, out_rdy,
    output in_rdy, out_data, out_valid, out_last
  );
endinterface

// File: rtl/window_stream_gen.sv
// rtl/window_stream_gen.sv - KxK sliding-window generator over a row-major pixel stream
//
// Purpose: buffers K-1 image lines per channel and emits one KxK window per channel for
//   every beat that completes a window (stride 1 or 2 on both axes). Image size and stride
//   are latched on start.
// Ports:
//   clk          clock, rising edge
//   reset        synchronous reset, active-high
//   start        1-cycle pulse, latches cfg_*, honoured only in IDLE
//   cfg_rows     image rows
//   cfg_cols     image columns
//   cfg_stride2  0: stride 1, 1: stride 2
//   strm         stream bundle (slave): pixel beats in, windows out
//   busy         high outside IDLE
//   done         1-cycle pulse after the final window is consumed
//   cfg_err      1-cycle pulse after a rejected start
module window_stream_gen #(
  parameter int PIX_W    = 8,
  parameter int CHANNELS = 1,
  parameter int K        = 3,
  parameter int MAX_COLS = 512,
  parameter int DIM_W    = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [DIM_W-1:0] cfg_rows,
  input  logic [DIM_W-1:0] cfg_cols,
  input  logic             cfg_stride2,
  window_stream_gen_if.slave strm,
  output logic             busy,
  output logic             done,
  output logic             cfg_err
);

  localparam int AW = (MAX_COLS > 1) ? $clog2(MAX_COLS) : 1;
  localparam int OW = CHANNELS * K * K * PIX_W;
  localparam logic [DIM_W-1:0] ONE = DIM_W'(1);
  localparam logic [DIM_W-1:0] KV  = DIM_W'(K);
  localparam logic [DIM_W-1:0] K1  = DIM_W'(K - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t           state, state_nx;
  logic [DIM_W-1:0] rows_q, cols_q, row, col, last_r, last_c;
  logic             s2_q, last_done;
  logic             out_valid_q, out_last_q, in_rdy_c;
  logic [OW-1:0]    out_data_q, pack_nx;

  // Line buffers: lb[ch][0] holds the oldest buffered row at each column.
  logic [PIX_W-1:0] lb   [CHANNELS][K-1][MAX_COLS];
  logic [PIX_W-1:0] win  [CHANNELS][K][K];
  logic [PIX_W-1:0] nwin [CHANNELS][K][K];
  logic [PIX_W-1:0] colv [CHANNELS][K];

  logic          cfg_ok, start_ok, accept, consume, emit, last_px, is_last_win;
  logic [AW-1:0] col_a;

  assign cfg_ok   = (int'(cfg_rows) >= K) && (int'(cfg_cols) >= K) && (int'(cfg_cols) <= MAX_COLS);
  assign start_ok = (state == IDLE) && start && cfg_ok;
  assign accept   = strm.in_valid && in_rdy_c;
  assign consume  = out_valid_q && strm.out_rdy;
  assign col_a    = col[AW-1:0];

  // Stride 2 keeps every other window counted from the first full one at (K-1, K-1).
  assign emit = (row >= K1) && (col >= K1) &&
                (!s2_q || ((row[0] == K1[0]) && (col[0] == K1[0])));
  assign last_px     = (row == rows_q - ONE) && (col == cols_q - ONE);
  assign is_last_win = (row == last_r) && (col == last_c);

  // Vertical slice at the current column: buffered rows on top, incoming pixel at the bottom.
  always_comb begin
    for (int ch = 0; ch < CHANNELS; ch++) begin
      for (int i = 0; i < K - 1; i++) colv[ch][i] = lb[ch][i][col_a];
      colv[ch][K-1] = strm.in_data[ch*PIX_W +: PIX_W];
    end
  end

  // Window after this beat: shift one column left, new slice enters at the right.
  always_comb begin
    pack_nx = '0;
    for (int ch = 0; ch < CHANNELS; ch++) begin
      for (int i = 0; i < K; i++) begin
        for (int j = 0; j < K; j++) begin
          nwin[ch][i][j] = (j == K - 1) ? colv[ch][i] : win[ch][i][(j + 1) % K];
          pack_nx[(ch*K*K + (K-1-j)*K + i)*PIX_W +: PIX_W] = nwin[ch][i][j];
        end
      end
    end
  end

  // Pixel storage is not reset; every window it feeds is fully overwritten first.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int ch = 0; ch < CHANNELS; ch++) begin
        for (int i = 0; i < K - 1; i++) lb[ch][i][col_a] <= colv[ch][i+1];
        for (int i = 0; i < K; i++)
          for (int j = 0; j < K; j++) win[ch][i][j] <= nwin[ch][i][j];
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // FSM next state. last_done covers a final window consumed before trailing pixels drain.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start_ok) state_nx = RUN;
      RUN:     if (accept && last_px) state_nx = DRAIN;
      DRAIN:   if (last_done || (consume && out_last_q)) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy     = (state != IDLE);
    in_rdy_c = (state == RUN) && (!out_valid_q || strm.out_rdy);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rows_q      <= '0;
      cols_q      <= '0;
      s2_q        <= 1'b0;
      last_r      <= '0;
      last_c      <= '0;
      row         <= '0;
      col         <= '0;
      last_done   <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      done        <= 1'b0;
      cfg_err     <= 1'b0;
    end else begin
      done    <= (state == DRAIN) && (state_nx == IDLE);
      cfg_err <= (state == IDLE) && start && !cfg_ok;

      if (start_ok) begin
        rows_q    <= cfg_rows;
        cols_q    <= cfg_cols;
        s2_q      <= cfg_stride2;
        // Last window row/col drop back by one when the stride-2 grid misses the edge.
        last_r    <= cfg_rows - ONE - {{(DIM_W-1){1'b0}}, cfg_stride2 & (cfg_rows[0] ^ KV[0])};
        last_c    <= cfg_cols - ONE - {{(DIM_W-1){1'b0}}, cfg_stride2 & (cfg_cols[0] ^ KV[0])};
        row       <= '0;
        col       <= '0;
        last_done <= 1'b0;
      end

      if (consume && out_last_q) last_done <= 1'b1;

      if (accept) begin
        if (col == cols_q - ONE) begin
          col <= '0;
          row <= row + ONE;
        end else begin
          col <= col + ONE;
        end
      end

      if (accept && emit) begin
        out_valid_q <= 1'b1;
        out_data_q  <= pack_nx;
        out_last_q  <= is_last_win;
      end else if (consume) begin
        out_valid_q <= 1'b0;
        out_last_q  <= 1'b0;
      end
    end
  end

  assign strm.in_rdy    = in_rdy_c;
  assign strm.out_valid = out_valid_q;
  assign strm.out_data  = out_data_q;
  assign strm.out_last  = out_last_q;

endmodule
